// File: rtl/acc_mq_datapath.sv
// rtl/acc_mq_datapath.sv - WIDTH-bit Acc/MQ/DR datapath with single-cycle ALU and shift-add multiply
// Ports:
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   INS, start            opcode and op strobe, accepted only while RDY is high
//   LDAcc, LDMQ, LDDR     load the selected register(s) from inBUS (IDLE, no start)
//   STAcc, STMQ, STDR     OR the selected register(s) onto outBUS (combinational)
//   inBUS, outBUS         shared load / store buses
//   RDY, done             idle indicator, one-cycle multiply-complete pulse
//   flagC, flagV, flagZ   carry / no-borrow, signed overflow, zero
module acc_mq_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [2:0]       INS,
  input  logic             start,
  input  logic             LDAcc,
  input  logic             LDMQ,
  input  logic             LDDR,
  input  logic             STAcc,
  input  logic             STMQ,
  input  logic             STDR,
  input  logic [WIDTH-1:0] inBUS,
  output logic [WIDTH-1:0] outBUS,
  output logic             RDY,
  output logic             done,
  output logic             flagC,
  output logic             flagV,
  output logic             flagZ
);

  localparam int CW  = $clog2(WIDTH) + 1;
  localparam int MSB = WIDTH - 1;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_MULU = 3'b110;
  localparam logic [2:0] OP_MULS = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIN} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  mq_q, mq_d;
  logic [WIDTH-1:0]  dr_q, dr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              muls_q, muls_d;
  logic              c_q, c_d, v_q, v_d, z_q, z_d;

  // ALU results carry one extra bit so carry / borrow fall out directly.
  logic [WIDTH:0] add_r, sub_r;
  assign add_r = {1'b0, acc_q} + {1'b0, dr_q};
  assign sub_r = {1'b0, acc_q} - {1'b0, dr_q};

  // Multiply iteration. Operands are extended to WIDTH+1 bits (sign-extended
  // for MULS) so bit WIDTH of the sum is the bit shifted into Acc's MSB:
  // the carry for MULU, the true sign of the partial product for MULS.
  // MULS subtracts DR on the last iteration because MQ's MSB has negative weight.
  logic           last_iter, do_sub, add_en;
  logic [WIDTH:0] acc_ext, dr_ext, addend, mul_sum;
  assign last_iter = (cnt_q == CW'(WIDTH - 1));
  assign do_sub    = muls_q & last_iter;
  assign add_en    = mq_q[0];
  assign acc_ext   = {muls_q & acc_q[MSB], acc_q};
  assign dr_ext    = {muls_q & dr_q[MSB], dr_q};
  assign addend    = add_en ? (do_sub ? ~dr_ext : dr_ext) : '0;
  assign mul_sum   = acc_ext + addend + {{WIDTH{1'b0}}, add_en & do_sub};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    dr_d    = dr_q;
    cnt_d   = cnt_q;
    muls_d  = muls_q;
    c_d     = c_q;
    v_d     = v_q;
    z_d     = z_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (INS)
            OP_NOP: ;
            OP_ADD: begin
              acc_d = add_r[MSB:0];
              c_d   = add_r[WIDTH];
              v_d   = (acc_q[MSB] == dr_q[MSB]) && (add_r[MSB] != acc_q[MSB]);
              z_d   = (add_r[MSB:0] == '0);
            end
            OP_SUB: begin
              acc_d = sub_r[MSB:0];
              c_d   = ~sub_r[WIDTH];
              v_d   = (acc_q[MSB] != dr_q[MSB]) && (sub_r[MSB] != acc_q[MSB]);
              z_d   = (sub_r[MSB:0] == '0);
            end
            OP_AND: begin
              acc_d = acc_q & dr_q;
              c_d   = 1'b0;
              v_d   = 1'b0;
              z_d   = ((acc_q & dr_q) == '0);
            end
            OP_OR: begin
              acc_d = acc_q | dr_q;
              c_d   = 1'b0;
              v_d   = 1'b0;
              z_d   = ((acc_q | dr_q) == '0);
            end
            OP_XOR: begin
              acc_d = acc_q ^ dr_q;
              c_d   = 1'b0;
              v_d   = 1'b0;
              z_d   = ((acc_q ^ dr_q) == '0);
            end
            OP_MULU, OP_MULS: begin
              acc_d   = '0;
              cnt_d   = '0;
              muls_d  = INS[0];
              c_d     = 1'b0;
              v_d     = 1'b0;
              state_d = S_MUL;
            end
          endcase
        end else begin
          if (LDAcc) acc_d = inBUS;
          if (LDMQ)  mq_d  = inBUS;
          if (LDDR)  dr_d  = inBUS;
        end
      end
      S_MUL: begin
        acc_d = {mul_sum[WIDTH], mul_sum[MSB:1]};
        mq_d  = {mul_sum[0], mq_q[MSB:1]};
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          z_d     = ({acc_d, mq_d} == '0);
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      mq_q    <= '0;
      dr_q    <= '0;
      cnt_q   <= '0;
      muls_q  <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      dr_q    <= dr_d;
      cnt_q   <= cnt_d;
      muls_q  <= muls_d;
      c_q     <= c_d;
      v_q     <= v_d;
      z_q     <= z_d;
    end
  end

  assign outBUS = ({WIDTH{STAcc}} & acc_q) | ({WIDTH{STMQ}} & mq_q) | ({WIDTH{STDR}} & dr_q);
  assign RDY    = (state_q == S_IDLE);
  assign done   = (state_q == S_FIN);
  assign flagC  = c_q;
  assign flagV  = v_q;
  assign flagZ  = z_q;

endmodule
